// File: rtl/cic_decimator.sv
// cic_decimator: N-stage CIC decimator with run-time power-of-two rate R = 2^k.
// It sits after the IIR notch stage. Output is gain-normalised, rounded
// half-up, and saturated to DATA_WIDTH, with overflow and underflow flags.
// Optional build macro CIC_GAIN_SHIFT_EN adds a gain_shift[1:0] input. That
// input lowers the normalising shift and left-shifts when the net shift is
// negative.
module cic_decimator #(
  parameter int DATA_WIDTH   = 16,
  parameter int DATA_FRAC    = 15,
  parameter int NUM_STAGES   = 5,
  parameter int MAX_DEC_LOG2 = 4,
  parameter int ACC_WIDTH    = DATA_WIDTH + NUM_STAGES * MAX_DEC_LOG2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic                         bypass,
  input  logic [2:0]                   dec_log2,
`ifdef CIC_GAIN_SHIFT_EN
  input  logic [1:0]                   gain_shift,
`endif
  input  logic signed [DATA_WIDTH-1:0] cic_in,
  output logic signed [DATA_WIDTH-1:0] cic_out,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         valid_out
);

  localparam int CNT_W = (MAX_DEC_LOG2 < 1) ? 1 : MAX_DEC_LOG2;
  // Extra headroom so a left shift of up to 3 bits cannot wrap before saturation.
  localparam int EXT_W = ACC_WIDTH + 3;
  // Position of the sign bit in the Q(DATA_WIDTH-DATA_FRAC).DATA_FRAC output format.
  localparam int SIGN_POS = (DATA_WIDTH - DATA_FRAC - 1) + DATA_FRAC;
  localparam logic [2:0] K_MAX = 3'(MAX_DEC_LOG2);
  localparam logic signed [EXT_W-1:0] SAT_MAX =
    $signed({{(EXT_W-SIGN_POS){1'b0}}, {SIGN_POS{1'b1}}});
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  // Round half-up on a positive shift, and left-shift on a negative shift.
  function automatic logic signed [EXT_W-1:0] scale_round(
    input logic signed [ACC_WIDTH-1:0] v,
    input int                          s
  );
    logic signed [EXT_W-1:0] x;
    logic signed [EXT_W-1:0] half;
    x    = $signed({{(EXT_W-ACC_WIDTH){v[ACC_WIDTH-1]}}, v});
    half = '0;
    if (s > 0) begin
      half[0] = 1'b1;
      half    = half <<< (s - 1);
      x       = (x + half) >>> s;
    end else if (s < 0) begin
      x = x <<< (-s);
    end
    return x;
  endfunction

  // Clamp to the output range. The result packs {overflow, underflow, data}.
  function automatic logic [DATA_WIDTH+1:0] saturate(input logic signed [EXT_W-1:0] x);
    if (x > SAT_MAX)
      return {2'b10, SAT_MAX[DATA_WIDTH-1:0]};
    else if (x < SAT_MIN)
      return {2'b01, SAT_MIN[DATA_WIDTH-1:0]};
    else
      return {2'b00, x[DATA_WIDTH-1:0]};
  endfunction

  logic signed [ACC_WIDTH-1:0] integ    [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] int_next [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] comb_dly [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] c        [NUM_STAGES+1];
  logic signed [ACC_WIDTH-1:0] dec_sample_p0;
  logic                        vld_p0;
  logic [CNT_W-1:0]            dec_cnt;
  logic [CNT_W-1:0]            cnt_last;
  logic [2:0]                  k_reg;
  logic [2:0]                  k_clamp;
  logic                        accept;
  logic                        cfg_change;
  logic                        comb_go;
  int                          gain_sh;
  int                          shift_amt;
  logic signed [EXT_W-1:0]     scaled;
  logic [DATA_WIDTH+1:0]       sat_res;

  // Decode the control: clamp k, detect an accepted sample, detect a rate change,
  // and decide whether the comb stage fires.
  always_comb begin
    k_clamp    = (dec_log2 > K_MAX) ? K_MAX : dec_log2;
    accept     = valid_in & ~bypass;
    cfg_change = (k_clamp != k_reg);
    cnt_last   = CNT_W'((32'd1 << k_reg) - 32'd1);
    // A rate change kills any decimated sample still waiting for the combs.
    comb_go    = vld_p0 & ~bypass & ~(accept & cfg_change);
  end

  // Integrator chain running at the input rate. Each stage adds the updated value of the stage before it.
  always_comb begin
    int_next[0] = integ[0] + $signed({{(ACC_WIDTH-DATA_WIDTH){cic_in[DATA_WIDTH-1]}}, cic_in});
    for (int i = 1; i < NUM_STAGES; i++)
      int_next[i] = integ[i] + int_next[i-1];
  end

  // Integrator state advances only on accepted samples. It wraps modulo 2^ACC_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STAGES; i++) integ[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_STAGES; i++) integ[i] <= int_next[i];
    end
  end

  // ---- stage p0: rate register, decimation counter, decimated sample ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg         <= '0;
      dec_cnt       <= '0;
      dec_sample_p0 <= '0;
      vld_p0        <= 1'b0;
    end else if (bypass) begin
      vld_p0 <= 1'b0;
    end else if (accept) begin
      if (cfg_change) begin
        k_reg   <= k_clamp;
        dec_cnt <= '0;
        vld_p0  <= 1'b0;
      end else if (dec_cnt == cnt_last) begin
        dec_cnt       <= '0;
        dec_sample_p0 <= int_next[NUM_STAGES-1];
        vld_p0        <= 1'b1;
      end else begin
        dec_cnt <= dec_cnt + 1'b1;
        vld_p0  <= 1'b0;
      end
    end else begin
      vld_p0 <= 1'b0;
    end
  end

  // Comb chain at the decimated rate, followed by the normalising shift and saturation.
  always_comb begin
`ifdef CIC_GAIN_SHIFT_EN
    gain_sh = int'(gain_shift);
`else
    gain_sh = 0;
`endif
    c[0] = dec_sample_p0;
    for (int i = 0; i < NUM_STAGES; i++)
      c[i+1] = c[i] - comb_dly[i];
    shift_amt = NUM_STAGES * int'(k_reg) - gain_sh;
    scaled    = scale_round(c[NUM_STAGES], shift_amt);
    sat_res   = saturate(scaled);
  end

  // Comb delay line. A rate change clears it, so the new rate starts from a known history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STAGES; i++) comb_dly[i] <= '0;
    end else if (accept && cfg_change) begin
      for (int i = 0; i < NUM_STAGES; i++) comb_dly[i] <= '0;
    end else if (comb_go) begin
      for (int i = 0; i < NUM_STAGES; i++) comb_dly[i] <= c[i];
    end
  end

  // ---- stage p1: output register. In bypass the input passes straight through ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cic_out   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      valid_out <= 1'b0;
    end else if (bypass) begin
      cic_out   <= cic_in;
      valid_out <= valid_in;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (comb_go) begin
      cic_out   <= sat_res[DATA_WIDTH-1:0];
      overflow  <= sat_res[DATA_WIDTH+1];
      underflow <= sat_res[DATA_WIDTH];
      valid_out <= 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Testbench for cic_decimator. The reference model keeps the full accepted-sample
// history. It computes each decimated output as an FIR with an N-fold boxcar
// impulse response, then rounds and saturates it.
module tb_cic_decimator;

  localparam int N    = 5;
  localparam int MAXK = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_in = 1'b0;
  logic        bypass = 1'b0;
  logic [2:0]  dec_log2 = 3'd0;
  logic [1:0]  gain_shift = 2'd0;
  logic [15:0] cic_in = 16'd0;
  logic [15:0] cic_out;
  logic        overflow, underflow, valid_out;

  cic_decimator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .bypass    (bypass),
    .dec_log2  (dec_log2),
`ifdef CIC_GAIN_SHIFT_EN
    .gain_shift(gain_shift),
`endif
    .cic_in    (cic_in),
    .cic_out   (cic_out),
    .overflow  (overflow),
    .underflow (underflow),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    logic [17:0] val;
    bit          chk;
  } exp_t;

  exp_t   exp_q[$];
  longint hist[$];
  int     mk = 0, mcnt = 0, skip = 0;

  // Reference output for the newest accepted sample at the current rate 2^mk.
  function automatic logic [17:0] model_out();
    longint h[$];
    longint nh[$];
    longint y;
    longint acc;
    int     r;
    int     n;
    int     s;
    r = 1 << mk;
    n = hist.size() - 1;
    y = 0;
    h = {1};
    repeat (N) begin
      nh = {};
      for (int j = 0; j < h.size() + r - 1; j++) begin
        acc = 0;
        for (int t = 0; t < r; t++)
          if (j - t >= 0 && j - t < h.size()) acc += h[j-t];
        nh.push_back(acc);
      end
      h = nh;
    end
    for (int j = 0; j < h.size() && j <= n; j++) y += h[j] * hist[n-j];
    s = N * mk - int'(gain_shift);
    if (s > 0)      y = (y + (longint'(1) << (s - 1))) >>> s;
    else if (s < 0) y = y <<< (-s);
    if (y > 32767)  return {2'b10, 16'h7FFF};
    if (y < -32768) return {2'b01, 16'h8000};
    return {2'b00, 16'(y)};
  endfunction

  // Drive one cycle and record what it should produce.
  task automatic step(input bit v, input logic [15:0] d);
    int kc;
    @(posedge clk);
    #1;
    valid_in = v;
    cic_in   = d;
    if (v) begin
      if (bypass) begin
        exp_q.push_back('{cyc + 1, {2'b00, d}, 1'b1});
      end else begin
        kc = (dec_log2 > 3'(MAXK)) ? MAXK : int'(dec_log2);
        hist.push_back(longint'($signed(d)));
        if (kc != mk) begin
          mk = kc; mcnt = 0; skip = N;
        end else if (mcnt == (1 << mk) - 1) begin
          mcnt = 0;
          exp_q.push_back('{cyc + 2, model_out(), skip == 0});
          if (skip > 0) skip--;
        end else begin
          mcnt++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'($urandom));
  endtask

  task automatic run_const(input logic [15:0] d, input int n);
    repeat (n) step(1'b1, d);
  endtask

  task automatic run_rand(input int n);
    repeat (n) step($urandom_range(0, 9) < 7, 16'($urandom));
  endtask

  // Assert reset between clock edges, check that the outputs clear at once, and reset the model.
  task automatic do_reset(input string tag);
    #3;
    rst_n = 1'b0;
    valid_in = 1'b0;
    #1;
    check({tag, "_cic_out"},   cic_out,   0);
    check({tag, "_valid_out"}, valid_out, 0);
    check({tag, "_overflow"},  overflow,  0);
    check({tag, "_underflow"}, underflow, 0);
    exp_q.delete();
    hist.delete();
    mk = 0; mcnt = 0; skip = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Output monitor. It samples on the falling edge and checks timing and value against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", valid_out, 0);
        end else begin
          check("latency", cyc, exp_q[0].due);
          if (exp_q[0].chk) check("output", {overflow, underflow, cic_out}, exp_q[0].val);
          void'(exp_q.pop_front());
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("missing_valid", valid_out, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    do_reset("reset");

    // k=2, constant 0x4000
    dec_log2 = 3'd2;
    run_const(16'h4000, 48);
    idle(3);

    // k=0 ramp: every sample emerges two cycles later, unchanged
    dec_log2 = 3'd0;
    for (int i = 1; i <= 20; i++) step(1'b1, 16'(i));
    idle(3);

    // k=4 at both full-scale extremes. dec_log2=7 must clamp to 4, so no rate change occurs.
    dec_log2 = 3'd4;
    run_const(16'h8000, 160);
    dec_log2 = 3'd7;
    run_const(16'h7FFF, 160);
    idle(3);

    // random data and random valid gaps at each rate
    for (int k = 0; k <= MAXK; k++) begin
      dec_log2 = 3'(k);
      run_rand(120);
      idle(3);
    end

    // bypass with valid toggling. Leave dec_cnt mid-count first so resumption is tested.
    dec_log2 = 3'd2;
    run_const(16'h1000, 42);
    idle(3);
    bypass = 1'b1;
    for (int i = 0; i < 12; i++) step(i[0], 16'h1234);
    idle(1);
    bypass = 1'b0;
    run_rand(60);
    idle(3);

    // rate change from 2 to 3 at constant 0x2000
    dec_log2 = 3'd2;
    run_const(16'h2000, 40);
    idle(3);
    dec_log2 = 3'd3;
    run_const(16'h2000, 100);

    // reset in the middle of the stream, then a fresh run
    @(posedge clk);
    do_reset("midreset");
    dec_log2 = 3'd1;
    idle(2);
    run_rand(60);
    idle(3);

`ifdef CIC_GAIN_SHIFT_EN
    gain_shift = 2'd2;
    dec_log2 = 3'd0;
    run_const(16'h3000, 12);
    run_const(16'hD000, 12);
    idle(3);
    gain_shift = 2'd0;
`endif

    idle(5);
    check("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
